pipelined_adder: RTL and testbench

- Parametrised, pipelined, registered successor to the 4-bit combinational adder.
- Splits a WIDTH-bit add/subtract into STAGES chunks of CHUNK=WIDTH/STAGES bits, one chunk per clock, with the carry registered between stages.
- Valid/ready handshake on both sides; supports back-pressure.
- Sits between operand-producing logic and the accumulator/ALU datapath, where a full-width carry chain would miss timing.

---
 rtl/pipelined_adder.sv | 84 ++++++++
 tb/tb_pipelined_adder.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit add/subtract split into STAGES chunks, one chunk per clock,
// with a registered carry between chunks and one global valid/ready stall.
module pipelined_adder #(
  parameter int WIDTH = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int CHUNK = WIDTH / STAGES;
  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] s_q [STAGES];
  logic             c_q [STAGES];
  logic             v_q [STAGES];
  logic             ovf_q;
  logic [WIDTH-1:0] a_in [STAGES];
  logic [WIDTH-1:0] b_in [STAGES];
  logic [WIDTH-1:0] s_in [STAGES];
  logic [WIDTH-1:0] s_d  [STAGES];
  logic             c_in [STAGES];
  logic             v_in [STAGES];
  logic [CHUNK:0]   t    [STAGES];
  logic             ovf_d;
  // Stage 0 inverts b once for subtract; the operand words then travel with the beat,
  // so later stages only ever add and the sub flag needs no register of its own.
  always_comb begin
    a_in[0] = a;
    b_in[0] = sub ? ~b : b;
    s_in[0] = '0;
    c_in[0] = sub | cin;
    v_in[0] = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      a_in[k] = a_q[k-1];
      b_in[k] = b_q[k-1];
      s_in[k] = s_q[k-1];
      c_in[k] = c_q[k-1];
      v_in[k] = v_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      t[k] = {1'b0, a_in[k][k*CHUNK +: CHUNK]} + {1'b0, b_in[k][k*CHUNK +: CHUNK]} + {{CHUNK{1'b0}}, c_in[k]};
      s_d[k] = s_in[k];
      s_d[k][k*CHUNK +: CHUNK] = t[k][CHUNK-1:0];
    end
    ovf_d = a_in[STAGES-1][WIDTH-1] ^ b_in[STAGES-1][WIDTH-1] ^ s_d[STAGES-1][WIDTH-1] ^ t[STAGES-1][CHUNK];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
        v_q[k] <= 1'b0;
      end
      ovf_q <= 1'b0;
    end else if (in_ready) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= a_in[k];
        b_q[k] <= b_in[k];
        s_q[k] <= s_d[k];
        c_q[k] <= t[k][CHUNK];
        v_q[k] <= v_in[k];
      end
      ovf_q <= ovf_d;
    end
  end
  assign out_valid = v_q[STAGES-1];
  assign in_ready  = !out_valid || out_ready;
  assign sum       = s_q[STAGES-1];
  assign cout      = c_q[STAGES-1];
  assign ovf       = ovf_q;
endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: three configurations (32/4, 8/1, 8/8) checked against a signed/unsigned
// arithmetic model with an in-order scoreboard and stall-aware latency tracking.
module tb_pipelined_adder;
  typedef struct {
    logic [31:0] s;
    logic        co;
    logic        of;
    int          acc;
    int          st;
  } exp_t;

  logic        clk = 0;
  logic        rst_n;
  logic [31:0] a = 0, b = 0;
  logic        cin = 0, sub = 0, out_ready = 1;
  logic        iv0 = 0, iv1 = 0, iv2 = 0;
  logic        ir0, ir1, ir2, ov0, ov1, ov2, co0, co1, co2, of0, of1, of2;
  logic [31:0] s0;
  logic [7:0]  s1, s2;
  int          checks = 0, failures = 0, cyc = 0, mode = 0;
  int          stalls [3] = '{0, 0, 0};
  bit          seen [3] = '{0, 0, 0};
  exp_t        q [3][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pipelined_adder #(.WIDTH(32), .STAGES(4)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(ov0), .out_ready(out_ready), .sum(s0), .cout(co0), .ovf(of0));
  pipelined_adder #(.WIDTH(8), .STAGES(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .a(a[7:0]), .b(b[7:0]), .cin(cin), .sub(sub),
    .out_valid(ov1), .out_ready(out_ready), .sum(s1), .cout(co1), .ovf(of1));
  pipelined_adder #(.WIDTH(8), .STAGES(8)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .a(a[7:0]), .b(b[7:0]), .cin(cin), .sub(sub),
    .out_valid(ov2), .out_ready(out_ready), .sum(s2), .cout(co2), .ovf(of2));

  function automatic int wid(int i);
    return i == 0 ? 32 : 8;
  endfunction

  function automatic int stg(int i);
    return i == 0 ? 4 : (i == 1 ? 1 : 8);
  endfunction

  // Result from plain integer arithmetic: unsigned view for sum/cout, signed view for ovf.
  function automatic exp_t model(int w, logic [31:0] x, logic [31:0] y, logic c, logic s);
    exp_t   m;
    longint mask = (longint'(1) << w) - 1;
    longint half = longint'(1) << (w - 1);
    longint ux = longint'(x) & mask;
    longint uy = longint'(y) & mask;
    longint sx = ux >= half ? ux - (mask + 1) : ux;
    longint sy = uy >= half ? uy - (mask + 1) : uy;
    longint r  = s ? ux - uy : ux + uy + longint'(c);
    longint sr = s ? sx - sy : sx + sy + longint'(c);
    m.s   = 32'(r & mask);
    m.co  = s ? (ux >= uy) : (r > mask);
    m.of  = (sr < -half) || (sr >= half);
    m.acc = 0;
    m.st  = 0;
    return m;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic logic rdy(int d);
    return d == 0 ? ir0 : (d == 1 ? ir1 : ir2);
  endfunction

  task automatic set_iv(int d, logic v);
    if (d == 0) iv0 = v;
    else if (d == 1) iv1 = v;
    else iv2 = v;
  endtask

  task automatic beat(int d, logic [31:0] x, logic [31:0] y, logic c, logic s);
    bit ok = 0;
    a = x; b = y; cin = c; sub = s;
    set_iv(d, 1'b1);
    for (int t = 0; t < 300 && !ok; t++) begin
      @(negedge clk);
      ok = rdy(d) && rst_n;
      @(posedge clk);
      #1;
    end
    set_iv(d, 1'b0);
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout dut=%0d actual=no_accept required=accept", d);
    end
  endtask

  task automatic drain(int d);
    for (int t = 0; t < 300 && q[d].size() != 0; t++) @(negedge clk);
    chk("drain_empty", q[d].size(), 0);
  endtask

  task automatic directed(string nm, logic [31:0] x, logic [31:0] y, logic c, logic s,
                          logic [31:0] es, logic eco, logic eof);
    exp_t m = model(32, x, y, c, s);
    chk({nm, "_model"}, {m.s, m.co, m.of}, {es, eco, eof});
    beat(0, x, y, c, s);
    for (int t = 0; t < 20 && !ov0; t++) @(negedge clk);
    chk({nm, "_dut"}, {ov0, s0, co0, of0}, {1'b1, es, eco, eof});
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] opnd(int w);
    logic [31:0] m = w == 32 ? 32'hFFFF_FFFF : 32'h0000_00FF;
    case ($urandom_range(0, 4))
      0: return 32'h0;
      1: return m;
      2: return (m >> 1) + 1;
      3: return m >> 1;
      default: return $urandom & m;
    endcase
  endfunction

  // Single compare process: checks every DUT every cycle against the scoreboard.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      logic v, ivl, irl, c, o;
      logic [31:0] s;
      exp_t e;
      v   = i == 0 ? ov0 : (i == 1 ? ov1 : ov2);
      ivl = i == 0 ? iv0 : (i == 1 ? iv1 : iv2);
      irl = i == 0 ? ir0 : (i == 1 ? ir1 : ir2);
      c   = i == 0 ? co0 : (i == 1 ? co1 : co2);
      o   = i == 0 ? of0 : (i == 1 ? of1 : of2);
      s   = i == 0 ? s0 : (i == 1 ? {24'h0, s1} : {24'h0, s2});
      if (!rst_n) begin
        q[i].delete();
        seen[i] = 0;
        chk("reset_outputs", {v, c, o, s}, 0);
      end else begin
        chk("in_ready_rule", irl, !v || out_ready);
        if (q[i].size() == 0) chk("idle_no_output", v, 0);
        else if (v) begin
          e = q[i][0];
          chk("result", {s, c, o}, {e.s, e.co, e.of});
          if (!seen[i]) begin
            chk("latency", cyc, e.acc + stg(i) - 1 + (stalls[i] - e.st));
            seen[i] = 1;
          end
          if (out_ready) begin
            void'(q[i].pop_front());
            seen[i] = 0;
          end else stalls[i]++;
        end
        if (ivl && irl) begin
          e = model(wid(i), a, b, cin, sub);
          e.acc = cyc + 1;
          e.st = stalls[i];
          q[i].push_back(e);
        end
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    out_ready = mode == 0 ? 1'b1 : (mode == 2 ? 1'b0 : ($urandom_range(0, 2) != 0));
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    directed("carry16", 32'h0000_FFFF, 32'h1, 0, 0, 32'h0001_0000, 0, 0);
    directed("carry32", 32'hFFFF_FFFF, 32'h0, 1, 0, 32'h0, 1, 0);
    directed("sub_ovf", 32'h8000_0000, 32'h1, 0, 1, 32'h7FFF_FFFF, 1, 1);
    directed("sub_borrow", 32'h5, 32'h7, 0, 1, 32'hFFFF_FFFE, 0, 0);
    directed("add_ovf", 32'h7FFF_FFFF, 32'h1, 0, 0, 32'h8000_0000, 0, 1);
    directed("sub_cin_ignored", 32'hA, 32'h3, 1, 1, 32'h7, 1, 0);
    for (int i = 0; i < 8; i++) beat(0, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'(i % 2));
    drain(0);
    mode = 2;
    @(posedge clk);
    #1;
    fork
      for (int i = 0; i < 8; i++) beat(0, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      begin
        repeat (10) @(negedge clk);
        chk("bp_in_ready", ir0, 0);
        chk("bp_out_valid", ov0, 1);
        mode = 0;
      end
    join
    drain(0);
    for (int i = 0; i < 3; i++) beat(0, $urandom, $urandom, 0, 0);
    rst_n = 0;
    iv0 = 1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    iv0 = 0;
    repeat (8) @(negedge clk);
    chk("post_reset_quiet", ov0, 0);
    @(posedge clk);
    #1;
    directed("after_reset", 32'h1234_5678, 32'h1111_1111, 1, 0, 32'h2345_678A, 0, 0);
    mode = 1;
    for (int i = 0; i < 200; i++) begin
      beat(0, opnd(32), opnd(32), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    end
    drain(0);
    for (int d = 1; d < 3; d++) begin
      beat(d, 32'hFF, 32'h01, 0, 0);
      for (int i = 0; i < 1000; i++) begin
        beat(d, opnd(8), opnd(8), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        if ($urandom_range(0, 7) == 0) begin @(posedge clk); #1; end
      end
      drain(d);
    end
    mode = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
